decode_seq: RTL and testbench

Registered, multi-cycle-capable instruction decoder for the pipelined ARM core, sitting between the D-stage instruction register and the E-stage datapath. It extends single-cycle control decode with three additions: a D→E pipeline register with stall/flush, a parametrised ALU control width, and a two-state micro-sequencer. The sequencer splits long multiplies (UMULL/SMULL/UMLAL/SMLAL) into two E-stage micro-ops while stalling decode.

---
 rtl/decode_pkg.sv | 59 +++++
 rtl/decode_core.sv | 96 +++++++++
 rtl/decode_seq.sv | 106 ++++++++++
 tb/tb_decode_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the D-stage decoder: opcodes, DP ALU codes,
// multiplier control bit positions and the long-multiply sequencer states.
package decode_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_ORR = 5'b00011;
  localparam logic [4:0] ALU_ADC = 5'b00100;
  localparam logic [4:0] ALU_SBC = 5'b00101;
  localparam logic [4:0] ALU_EOR = 5'b00110;
  localparam logic [4:0] ALU_RSB = 5'b01000;
  localparam logic [4:0] ALU_RSC = 5'b01100;
  localparam logic [4:0] ALU_BIC = 5'b10010;

  localparam int MUL_SEL_BIT    = 5;
  localparam int MUL_ACC_BIT    = 2;
  localparam int MUL_HI_BIT     = 1;
  localparam int MUL_SIGNED_BIT = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    LONG_HI = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       no_write;
    logic       ig_rn;
    logic [1:0] flag_w;
    logic [3:0] wa3;
  } ctrl_t;

  // Funct[4:1] to 5-bit ALU code; MVN and anything unlisted fall back to ADD.
  function automatic logic [4:0] dp_alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0000, 4'b1000: return ALU_AND;
      4'b0001, 4'b1001: return ALU_EOR;
      4'b0010, 4'b1010: return ALU_SUB;
      4'b0011:          return ALU_RSB;
      4'b0101:          return ALU_ADC;
      4'b0110:          return ALU_SBC;
      4'b0111:          return ALU_RSC;
      4'b1100:          return ALU_ORR;
      4'b1110:          return ALU_BIC;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational instruction decode: main decode, DP ALU decode and
// multiply classification. uop_hi selects the high-half fields of a long multiply.
module decode_core
  import decode_pkg::*;
#(
  parameter int ALUC_W = 6,
  parameter bit EN_MUL = 1'b1
) (
  input  logic [31:0]       instr,
  input  logic              uop_hi,
  output logic [1:0]        reg_src,
  output logic [1:0]        imm_src,
  output ctrl_t             ctrl,
  output logic [ALUC_W-1:0] alu_control,
  output logic              is_long,
  output logic              is_real
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       s_bit;
  logic       is_mul;
  logic [4:0] dp_code;
  logic       unused_instr;

  assign op       = instr[27:26];
  assign funct    = instr[25:20];
  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign is_mul   = EN_MUL && (op == OP_DP) && !funct[5] && (instr[7:4] == 4'b1001);
  assign is_long  = is_mul && instr[23];
  assign is_real  = (op != 2'b11);
  assign dp_code  = dp_alu_code(cmd);
  assign unused_instr = ^{instr[31:28], instr[11:8], instr[3:0]};

  always_comb begin
    reg_src     = 2'b00;
    imm_src     = 2'b00;
    ctrl        = '0;
    alu_control = '0;
    ctrl.wa3    = instr[15:12];

    case (op)
      OP_DP: begin
        ctrl.reg_w   = 1'b1;
        ctrl.alu_src = funct[5];
      end
      OP_MEM: begin
        imm_src      = 2'b01;
        ctrl.alu_src = 1'b1;
        if (funct[0]) begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_w      = 1'b1;
        end else begin
          reg_src    = 2'b10;
          ctrl.mem_w = 1'b1;
        end
      end
      OP_BR: begin
        reg_src      = 2'b01;
        imm_src      = 2'b10;
        ctrl.alu_src = 1'b1;
        ctrl.branch  = 1'b1;
      end
      default: ;
    endcase

    // Multiply fields ignore Funct[4:1] so NoWrite/IgRn can never leak in.
    if (op == OP_DP) begin
      if (is_mul) begin
        alu_control[MUL_SEL_BIT] = 1'b1;
        alu_control[MUL_ACC_BIT] = instr[21];
        if (is_long) begin
          alu_control[MUL_SIGNED_BIT] = instr[22];
          alu_control[MUL_HI_BIT]     = uop_hi;
          if (uop_hi) begin
            ctrl.wa3    = instr[19:16];
            ctrl.flag_w = {s_bit, 1'b0};
          end
        end else begin
          ctrl.wa3    = instr[19:16];
          ctrl.flag_w = {s_bit, 1'b0};
        end
      end else begin
        alu_control[4:0] = dp_code;
        ctrl.no_write     = (cmd[3:2] == 2'b10);
        ctrl.ig_rn        = (cmd == 4'b1101);
        ctrl.flag_w       = {s_bit, s_bit & ~dp_code[1]};
      end
    end

    ctrl.pcs = ((ctrl.wa3 == 4'hF) && ctrl.reg_w) || ctrl.branch;
  end

endmodule

// File: rtl/decode_seq.sv
// Registered decoder with D->E pipeline register (stall/flush) and a
// two-state sequencer that splits long multiplies into two E-stage micro-ops.
module decode_seq
  import decode_pkg::*;
#(
  parameter int ALUC_W = 6,
  parameter bit EN_MUL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       InstrD,
  input  logic              ValidD,
  input  logic              StallE,
  input  logic              FlushE,
  output logic [1:0]        RegSrcD,
  output logic [1:0]        ImmSrcD,
  output logic              StallD,
  output logic              ValidE,
  output logic              PCSE,
  output logic              RegWE,
  output logic              MemWE,
  output logic              MemtoRegE,
  output logic              ALUSrcE,
  output logic              BranchE,
  output logic              NoWriteE,
  output logic              IgRnE,
  output logic [1:0]        FlagWE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [3:0]        WA3E,
  output logic              UopE
);

  seq_state_t        state, state_nxt;
  ctrl_t             ctrl_p0, ctrl_p1;
  logic [ALUC_W-1:0] aluc_p0, aluc_p1;
  logic              vld_p0, vld_p1;
  logic              uop_p0, uop_p1;
  logic              is_long;
  logic              is_real;
  logic              uop_hi;

  assign uop_hi = (state == LONG_HI);

  // Stage p0: decode of the D-stage instruction
  decode_core #(
    .ALUC_W (ALUC_W),
    .EN_MUL (EN_MUL)
  ) u_core (
    .instr       (InstrD),
    .uop_hi      (uop_hi),
    .reg_src     (RegSrcD),
    .imm_src     (ImmSrcD),
    .ctrl        (ctrl_p0),
    .alu_control (aluc_p0),
    .is_long     (is_long),
    .is_real     (is_real)
  );

  assign vld_p0 = ValidD && is_real;
  assign uop_p0 = uop_hi && is_long;

  always_comb begin
    StallD    = StallE || ((state == IDLE) && ValidD && is_long);
    state_nxt = state;
    case (state)
      IDLE:    if (ValidD && is_long && !StallE) state_nxt = LONG_HI;
      LONG_HI: if (FlushE || !StallE)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p1: D->E register; flush wins over stall
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      aluc_p1 <= '0;
      uop_p1  <= 1'b0;
    end else if (!StallE) begin
      vld_p1  <= vld_p0;
      ctrl_p1 <= vld_p0 ? ctrl_p0 : '0;
      aluc_p1 <= vld_p0 ? aluc_p0 : '0;
      uop_p1  <= vld_p0 && uop_p0;
    end
  end

  assign ValidE      = vld_p1;
  assign PCSE        = ctrl_p1.pcs;
  assign RegWE       = ctrl_p1.reg_w;
  assign MemWE       = ctrl_p1.mem_w;
  assign MemtoRegE   = ctrl_p1.mem_to_reg;
  assign ALUSrcE     = ctrl_p1.alu_src;
  assign BranchE     = ctrl_p1.branch;
  assign NoWriteE    = ctrl_p1.no_write;
  assign IgRnE       = ctrl_p1.ig_rn;
  assign FlagWE      = ctrl_p1.flag_w;
  assign ALUControlE = aluc_p1;
  assign WA3E        = ctrl_p1.wa3;
  assign UopE        = uop_p1;

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: directed decode table, long-multiply corner sequences,
// and randomized traffic against a behavioural model (EN_MUL=1 and EN_MUL=0 builds).
module tb_decode_seq;

  typedef struct packed {
    logic       valid;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       nowrite;
    logic       ign;
    logic [1:0] flagw;
    logic [5:0] aluc;
    logic [3:0] wa3;
    logic       uop;
  } e_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  rsis;
    e_t          e;
  } vec_t;

  localparam logic [4:0] ALU_TAB [16] = '{
    5'b00010, 5'b00110, 5'b00001, 5'b01000, 5'b00000, 5'b00100, 5'b00101, 5'b01100,
    5'b00010, 5'b00110, 5'b00001, 5'b00000, 5'b00011, 5'b00000, 5'b10010, 5'b00000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] InstrD = '0;
  logic        ValidD = 1'b0;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;

  logic [1:0] RegSrcD, ImmSrcD, FlagWE, RegSrcD_nm, ImmSrcD_nm, FlagWE_nm;
  logic       StallD, ValidE, PCSE, RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, NoWriteE, IgRnE, UopE;
  logic       StallD_nm, ValidE_nm, PCSE_nm, RegWE_nm, MemWE_nm, MemtoRegE_nm, ALUSrcE_nm;
  logic       BranchE_nm, NoWriteE_nm, IgRnE_nm, UopE_nm;
  logic [5:0] ALUControlE, ALUControlE_nm;
  logic [3:0] WA3E, WA3E_nm;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tab [16];

  always #5 clk = ~clk;

  decode_seq #(.ALUC_W(6), .EN_MUL(1'b1)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .StallD(StallD), .ValidE(ValidE), .PCSE(PCSE),
    .RegWE(RegWE), .MemWE(MemWE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
    .NoWriteE(NoWriteE), .IgRnE(IgRnE), .FlagWE(FlagWE), .ALUControlE(ALUControlE),
    .WA3E(WA3E), .UopE(UopE));

  decode_seq #(.ALUC_W(6), .EN_MUL(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .RegSrcD(RegSrcD_nm), .ImmSrcD(ImmSrcD_nm), .StallD(StallD_nm), .ValidE(ValidE_nm),
    .PCSE(PCSE_nm), .RegWE(RegWE_nm), .MemWE(MemWE_nm), .MemtoRegE(MemtoRegE_nm),
    .ALUSrcE(ALUSrcE_nm), .BranchE(BranchE_nm), .NoWriteE(NoWriteE_nm), .IgRnE(IgRnE_nm),
    .FlagWE(FlagWE_nm), .ALUControlE(ALUControlE_nm), .WA3E(WA3E_nm), .UopE(UopE_nm));

  e_t act0, act1;
  assign act0 = {ValidE, PCSE, RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, NoWriteE, IgRnE,
                 FlagWE, ALUControlE, WA3E, UopE};
  assign act1 = {ValidE_nm, PCSE_nm, RegWE_nm, MemWE_nm, MemtoRegE_nm, ALUSrcE_nm, BranchE_nm,
                 NoWriteE_nm, IgRnE_nm, FlagWE_nm, ALUControlE_nm, WA3E_nm, UopE_nm};

  function automatic e_t mk(input logic v, pcs, rw, mw, m2r, as, br, nw, ig,
                            input logic [1:0] fw, input logic [5:0] alu,
                            input logic [3:0] wa3, input logic uop);
    return {v, pcs, rw, mw, m2r, as, br, nw, ig, fw, alu, wa3, uop};
  endfunction

  // Reference decode from the instruction-set rules; hi = high half of a long multiply.
  function automatic e_t model_dec(input logic [31:0] i, input logic en_mul, input logic hi);
    e_t e;
    logic [1:0] op;
    logic [3:0] cmd;
    logic s, mul, lng;
    e   = '0;
    op  = i[27:26];
    cmd = i[24:21];
    s   = i[20];
    mul = en_mul && op == 2'b00 && !i[25] && i[7:4] == 4'b1001;
    lng = mul && i[23];
    if (op == 2'b11) return e;
    e.valid = 1'b1;
    e.wa3   = i[15:12];
    if (op == 2'b00) begin
      e.regw   = 1'b1;
      e.alusrc = i[25];
      if (mul) begin
        e.aluc = {1'b1, 2'b00, i[21], lng & hi, lng & i[22]};
        if (!lng || hi) begin
          e.wa3   = i[19:16];
          e.flagw = {s, 1'b0};
        end
        e.uop = lng && hi;
      end else begin
        e.aluc    = {1'b0, ALU_TAB[cmd]};
        e.nowrite = (cmd >= 4'd8 && cmd <= 4'd11);
        e.ign     = (cmd == 4'd13);
        e.flagw   = {s, s && !e.aluc[1]};
      end
    end else if (op == 2'b01) begin
      e.alusrc = 1'b1;
      if (i[20]) begin
        e.regw     = 1'b1;
        e.memtoreg = 1'b1;
      end else begin
        e.memw = 1'b1;
      end
    end else begin
      e.alusrc = 1'b1;
      e.branch = 1'b1;
    end
    e.pcs = (e.regw && e.wa3 == 4'd15) || e.branch;
    return e;
  endfunction

  function automatic logic [3:0] model_src(input logic [31:0] i);
    case (i[27:26])
      2'b00:   return 4'b0000;
      2'b01:   return i[20] ? 4'b0001 : 4'b1001;
      2'b10:   return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0, 1:    i[27:26] = 2'b00;
      2:       i[27:26] = 2'b01;
      3:       i[27:26] = 2'b10;
      default: begin
        i[27:24] = 4'b0000;
        i[7:4]   = 4'b1001;
      end
    endcase
    return i;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [31:0] i, input logic v, input logic s, input logic f);
    InstrD = i;
    ValidD = v;
    StallE = s;
    FlushE = f;
    #1;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] UMULL  = 32'hE0821493;
  localparam logic [31:0] SMLALS = 32'hE0F21493;
  localparam logic [31:0] ADDI   = 32'hE2921005;

  initial begin
    e_t u0, u1, s0, s1, nm0, exp0, exp1;
    logic [31:0] ri;
    logic rv, rs, rf, hi_m, st_m, lng;

    tab[0]  = '{32'hE2921005, 4'b0000, mk(1,0,1,0,0,1,0,0,0,2'b11,6'b000000,4'd1,0)};
    tab[1]  = '{32'hE1530004, 4'b0000, mk(1,0,1,0,0,0,0,1,0,2'b11,6'b000001,4'd0,0)};
    tab[2]  = '{32'hE1A0F000, 4'b0000, mk(1,1,1,0,0,0,0,0,1,2'b00,6'b000000,4'd15,0)};
    tab[3]  = '{32'hE0165007, 4'b0000, mk(1,0,1,0,0,0,0,0,0,2'b10,6'b000010,4'd5,0)};
    tab[4]  = '{32'hE38980FF, 4'b0000, mk(1,0,1,0,0,1,0,0,0,2'b00,6'b000011,4'd8,0)};
    tab[5]  = '{32'hE3D22001, 4'b0000, mk(1,0,1,0,0,1,0,0,0,2'b10,6'b010010,4'd2,0)};
    tab[6]  = '{32'hE0E21003, 4'b0000, mk(1,0,1,0,0,0,0,0,0,2'b00,6'b001100,4'd1,0)};
    tab[7]  = '{32'hE0D44004, 4'b0000, mk(1,0,1,0,0,0,0,0,0,2'b11,6'b000101,4'd4,0)};
    tab[8]  = '{32'hE5921004, 4'b0001, mk(1,0,1,0,1,1,0,0,0,2'b00,6'b000000,4'd1,0)};
    tab[9]  = '{32'hE590F000, 4'b0001, mk(1,1,1,0,1,1,0,0,0,2'b00,6'b000000,4'd15,0)};
    tab[10] = '{32'hE5843008, 4'b1001, mk(1,0,0,1,0,1,0,0,0,2'b00,6'b000000,4'd3,0)};
    tab[11] = '{32'hEA000010, 4'b0110, mk(1,1,0,0,0,1,1,0,0,2'b00,6'b000000,4'd0,0)};
    tab[12] = '{32'hE1310002, 4'b0000, mk(1,0,1,0,0,0,0,1,0,2'b10,6'b000110,4'd0,0)};
    tab[13] = '{32'hE0010392, 4'b0000, mk(1,0,1,0,0,0,0,0,0,2'b00,6'b100000,4'd1,0)};
    tab[14] = '{32'hE0347695, 4'b0000, mk(1,0,1,0,0,0,0,0,0,2'b10,6'b100100,4'd4,0)};
    tab[15] = '{32'hE2821093, 4'b0000, mk(1,0,1,0,0,1,0,0,0,2'b00,6'b000000,4'd1,0)};

    u0  = mk(1,0,1,0,0,0,0,0,0,2'b00,6'b100000,4'd1,0);
    u1  = mk(1,0,1,0,0,0,0,0,0,2'b00,6'b100010,4'd2,1);
    s0  = mk(1,0,1,0,0,0,0,0,0,2'b00,6'b100101,4'd1,0);
    s1  = mk(1,0,1,0,0,0,0,0,0,2'b10,6'b100111,4'd2,1);
    nm0 = mk(1,0,1,0,0,0,0,0,0,2'b00,6'b000000,4'd1,0);

    // Reset state
    reset = 1'b1;
    apply(32'h0, 0, 0, 0);
    clk_edge();
    clk_edge();
    check("reset_e", 32'(act0), 32'(0));
    check("reset_e_nm", 32'(act1), 32'(0));
    check("reset_stalld", 32'(StallD), 32'(0));
    reset = 1'b0;

    // Directed decode table
    for (int k = 0; k < 16; k++) begin
      apply(tab[k].instr, 1, 0, 0);
      check($sformatf("tab%0d_stalld", k), 32'(StallD), 32'(0));
      check($sformatf("tab%0d_srcsel", k), 32'({RegSrcD, ImmSrcD}), 32'(tab[k].rsis));
      clk_edge();
      check($sformatf("tab%0d_e", k), 32'(act0), 32'(tab[k].e));
    end
    apply(32'h0, 0, 0, 0);
    clk_edge();
    check("bubble_e", 32'(act0), 32'(0));

    // UMULL: two micro-ops; EN_MUL=0 build sees a plain DP op
    apply(UMULL, 1, 0, 0);
    check("umull_stalld0", 32'(StallD), 32'(1));
    check("umull_nm_stalld", 32'(StallD_nm), 32'(0));
    clk_edge();
    check("umull_uop0", 32'(act0), 32'(u0));
    check("umull_nm_e", 32'(act1), 32'(nm0));
    check("umull_stalld1", 32'(StallD), 32'(0));
    clk_edge();
    check("umull_uop1", 32'(act0), 32'(u1));
    apply(32'h0, 0, 0, 0);
    clk_edge();
    check("umull_after", 32'(act0), 32'(0));

    // SMLALS with E stalled three cycles in LONG_HI
    apply(SMLALS, 1, 0, 0);
    clk_edge();
    check("smlal_uop0", 32'(act0), 32'(s0));
    apply(SMLALS, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("smlal_hold%0d_stalld", k), 32'(StallD), 32'(1));
      clk_edge();
      check($sformatf("smlal_hold%0d_e", k), 32'(act0), 32'(s0));
    end
    apply(SMLALS, 1, 0, 0);
    check("smlal_stalld", 32'(StallD), 32'(0));
    clk_edge();
    check("smlal_uop1", 32'(act0), 32'(s1));
    apply(32'h0, 0, 0, 0);
    clk_edge();

    // FlushE in LONG_HI aborts the sequence
    apply(UMULL, 1, 0, 0);
    clk_edge();
    check("flush_uop0", 32'(act0), 32'(u0));
    apply(UMULL, 1, 0, 1);
    clk_edge();
    check("flush_e", 32'(act0), 32'(0));
    apply(32'h0, 0, 0, 0);
    check("flush_stalld", 32'(StallD), 32'(0));
    clk_edge();
    check("flush_no_uop1", 32'(act0), 32'(0));
    apply(UMULL, 1, 0, 0);
    check("flush_idle_stalld", 32'(StallD), 32'(1));
    clk_edge();
    check("flush_restart_uop0", 32'(act0), 32'(u0));
    clk_edge();
    check("flush_restart_uop1", 32'(act0), 32'(u1));

    // Reset in LONG_HI
    apply(UMULL, 1, 0, 0);
    clk_edge();
    check("rst_uop0", 32'(act0), 32'(u0));
    reset = 1'b1;
    clk_edge();
    check("rst_e", 32'(act0), 32'(0));
    reset = 1'b0;
    apply(UMULL, 1, 0, 0);
    check("rst_idle_stalld", 32'(StallD), 32'(1));
    clk_edge();
    check("rst_restart_uop0", 32'(act0), 32'(u0));
    clk_edge();
    check("rst_restart_uop1", 32'(act0), 32'(u1));

    // Flush beats stall; flush in IDLE still accepts a long multiply
    apply(ADDI, 1, 1, 1);
    clk_edge();
    check("flush_over_stall", 32'(act0), 32'(0));
    apply(UMULL, 1, 0, 1);
    check("idle_flush_stalld", 32'(StallD), 32'(1));
    clk_edge();
    check("idle_flush_e", 32'(act0), 32'(0));
    apply(32'h0, 0, 0, 0);
    check("idle_flush_hi_stalld", 32'(StallD), 32'(0));
    clk_edge();
    apply(UMULL, 1, 0, 0);
    check("idle_flush_back_stalld", 32'(StallD), 32'(1));
    clk_edge();
    clk_edge();
    apply(32'h0, 0, 0, 0);
    clk_edge();

    // Randomized traffic against the model
    reset = 1'b1;
    clk_edge();
    reset = 1'b0;
    exp0 = '0;
    exp1 = '0;
    hi_m = 1'b0;
    st_m = 1'b0;
    ri   = '0;
    rv   = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!st_m) begin
        ri = rand_instr();
        rv = ($urandom_range(0, 7) != 0);
      end
      rs = ($urandom_range(0, 4) == 0);
      rf = ($urandom_range(0, 9) == 0);
      apply(ri, rv, rs, rf);
      lng  = ri[27:26] == 2'b00 && !ri[25] && ri[7:4] == 4'b1001 && ri[23];
      st_m = rs || (!hi_m && rv && lng);
      check("rnd_stalld", 32'(StallD), 32'(st_m));
      check("rnd_stalld_nm", 32'(StallD_nm), 32'(rs));
      check("rnd_srcsel", 32'({RegSrcD, ImmSrcD}), 32'(model_src(ri)));
      if (rf) begin
        exp0 = '0;
        exp1 = '0;
      end else if (!rs) begin
        exp0 = rv ? model_dec(ri, 1'b1, hi_m) : '0;
        exp1 = rv ? model_dec(ri, 1'b0, 1'b0) : '0;
      end
      hi_m = hi_m ? (rs && !rf) : (!rs && rv && lng);
      clk_edge();
      check("rnd_e", 32'(act0), 32'(exp0));
      check("rnd_e_nm", 32'(act1), 32'(exp1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
